framebuffer_reader: RTL and testbench



---
 rtl/framebuffer_reader.sv | 196 +++++++++++++++++++
 tb/tb_framebuffer_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | framebuffer_reader: row-major scan-out of the framebuffer read port onto a |
// | tagged valid/ready pixel stream. Option: FB_READER_LINE_DOUBLE_EN.          |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module framebuffer_reader #(
  parameter int WIDTH     = 16,
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  buf_ready,
  output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0] addr_read,
  input  logic [WIDTH-1:0]                      data_in,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [WIDTH-1:0]                      m_data,
  output logic                                  m_sol,
  output logic                                  m_eol,
  output logic                                  m_eof,
  output logic                                  busy,
  output logic                                  done
);

  localparam int ADDR_WIDTH = $clog2(FB_WIDTH*FB_HEIGHT);
  localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam logic [XW-1:0]         X_LAST   = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0]         Y_LAST   = YW'(FB_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_STREAMING = 2'd1,
    S_DRAIN     = 2'd2
  } state_t;

  state_t                r_state;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic                  r_inflight;
  logic                  r_sol_d;
  logic                  r_eol_d;
  logic                  r_eof_d;
`ifdef FB_READER_LINE_DOUBLE_EN
  logic                  r_pass;
`endif

  logic [WIDTH-1:0]      r_fifo_data [0:1];
  logic [1:0]            r_fifo_sol;
  logic [1:0]            r_fifo_eol;
  logic [1:0]            r_fifo_eof;
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic       w_pop;
  logic       w_credit;
  logic       w_issue;
  logic       w_x_last;
  logic       w_y_last;
  logic       w_second_pass;
  logic       w_eof;
  logic [1:0] w_count_next;

  assign w_pop    = m_valid && m_ready;
  // Slots already committed (stored + returning) after this cycle's pop must leave room.
  assign w_credit = (({1'b0, r_count} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;
  assign w_issue  = (r_state == S_STREAMING) && buf_ready && w_credit;

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);
`ifdef FB_READER_LINE_DOUBLE_EN
  assign w_second_pass = r_pass;
`else
  assign w_second_pass = 1'b1;
`endif
  assign w_eof        = w_x_last && w_y_last && w_second_pass;
  assign w_count_next = (r_count + {1'b0, r_inflight}) - {1'b0, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      addr_read  <= '0;
      r_inflight <= 1'b0;
      r_sol_d    <= 1'b0;
      r_eol_d    <= 1'b0;
      r_eof_d    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef FB_READER_LINE_DOUBLE_EN
      r_pass     <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_sol_d <= (r_x == '0);
        r_eol_d <= w_x_last;
        r_eof_d <= w_eof;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_STREAMING;
            busy       <= 1'b1;
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
            addr_read  <= '0;
`ifdef FB_READER_LINE_DOUBLE_EN
            r_pass     <= 1'b0;
`endif
          end
        end
        S_STREAMING: begin
          if (w_issue) begin
            if (w_eof) begin
              // Address holds at the last pixel; wrap happens only through a new start.
              r_state <= S_DRAIN;
            end else if (w_x_last) begin
              r_x <= '0;
`ifdef FB_READER_LINE_DOUBLE_EN
              if (!r_pass) begin
                r_pass    <= 1'b1;
                addr_read <= r_row_base;
              end else begin
                r_pass     <= 1'b0;
                r_row_base <= r_row_base + ROW_STEP;
                addr_read  <= r_row_base + ROW_STEP;
                r_y        <= r_y + YW'(1);
              end
`else
              r_row_base <= r_row_base + ROW_STEP;
              addr_read  <= r_row_base + ROW_STEP;
              r_y        <= r_y + YW'(1);
`endif
            end else begin
              r_x       <= r_x + XW'(1);
              addr_read <= addr_read + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!r_inflight && (w_count_next == 2'd0)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Returning read data is written every cycle it is flagged in flight; credit prevents overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_sol     <= '0;
      r_fifo_eol     <= '0;
      r_fifo_eof     <= '0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= '0;
    end else begin
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= data_in;
        r_fifo_sol[r_wr_ptr]  <= r_sol_d;
        r_fifo_eol[r_wr_ptr]  <= r_eol_d;
        r_fifo_eof[r_wr_ptr]  <= r_eof_d;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;
    end
  end

  assign m_valid = (r_count != 2'd0);
  assign m_data  = r_fifo_data[r_rd_ptr];
  assign m_sol   = r_fifo_sol[r_rd_ptr];
  assign m_eol   = r_fifo_eol[r_rd_ptr];
  assign m_eof   = r_fifo_eof[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_framebuffer_reader: scoreboard bench for framebuffer_reader on a 4x3     |
// | frame with mem[a]=a. Option: FB_READER_LINE_DOUBLE_EN.                      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_framebuffer_reader;

  localparam int WIDTH     = 16;
  localparam int FB_WIDTH  = 4;
  localparam int FB_HEIGHT = 3;
  localparam int AW        = $clog2(FB_WIDTH*FB_HEIGHT);
`ifdef FB_READER_LINE_DOUBLE_EN
  localparam int PASSES    = 2;
`else
  localparam int PASSES    = 1;
`endif
  localparam int FRAME_BEATS = FB_WIDTH * FB_HEIGHT * PASSES;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             buf_ready;
  logic [AW-1:0]    addr_read;
  logic [WIDTH-1:0] data_in = '0;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_sol;
  logic             m_eol;
  logic             m_eof;
  logic             busy;
  logic             done;

  framebuffer_reader #(
    .WIDTH    (WIDTH),
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .buf_ready(buf_ready),
    .addr_read(addr_read),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sol    (m_sol),
    .m_eol    (m_eol),
    .m_eof    (m_eof),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Framebuffer model: registered read, mem[a] = a.
  always @(posedge clk) data_in <= WIDTH'(addr_read);

  int          n_checks = 0;
  int          n_errors = 0;
  int          beats    = 0;
  int          done_cnt = 0;
  int          ready_mode = 0;
  logic [18:0] sb [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < FB_HEIGHT; r++)
      for (int p = 0; p < PASSES; p++)
        for (int x = 0; x < FB_WIDTH; x++)
          sb.push_back({16'(r*FB_WIDTH + x), x == 0, x == FB_WIDTH-1,
                        (x == FB_WIDTH-1) && (r == FB_HEIGHT-1) && (p == PASSES-1)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 200) begin
      tick();
      n++;
    end
    if (beats < target) check_eq("beats_timeout", beats, target);
  endtask

  // Sink backpressure: always ready, or the repeating 1,0,0,1 pattern.
  initial begin
    int cyc;
    cyc = 0;
    m_ready = 1'b1;
    forever begin
      tick();
      cyc++;
      m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end
  end

  // Output monitor sampling mid-cycle.
  initial begin
    logic        prev_stall;
    logic        exp_done;
    logic [18:0] prev_head;
    logic [18:0] exp_beat;
    prev_stall = 1'b0;
    exp_done   = 1'b0;
    prev_head  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        exp_done   = 1'b0;
      end else begin
        if (prev_stall) check_eq("head_hold", {m_valid, m_data, m_sol, m_eol, m_eof}, {1'b1, prev_head});
        if (exp_done || done) begin
          check_eq("done_after_eof", done, exp_done);
          check_eq("busy_at_done", busy, 1'b0);
        end
        if (done) done_cnt++;
        exp_done = 1'b0;
        if (m_valid && m_ready) begin
          beats++;
          if (sb.size() == 0) begin
            check_eq("unexpected_beat", m_data, 32'hffff_ffff);
          end else begin
            exp_beat = sb.pop_front();
            check_eq("beat", {m_data, m_sol, m_eol, m_eof}, exp_beat);
          end
          exp_done = m_eof;
        end
        prev_stall = m_valid && !m_ready;
        prev_head  = {m_data, m_sol, m_eol, m_eof};
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    buf_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_addr", addr_read, 0);
    check_eq("rst_head", {m_data, m_sol, m_eol, m_eof}, 0);
    rst = 1'b0;
    tick();

    // Free run with first-beat latency.
    beats = 0;
    push_frame();
    pulse_start();
    check_eq("busy_after_start", busy, 1);
    check_eq("addr_first", addr_read, 0);
    check_eq("valid_e0", m_valid, 0);
    tick();
    check_eq("valid_e1", m_valid, 0);
    tick();
    check_eq("valid_e2", m_valid, 1);
    check_eq("first_data", m_data, 0);
    wait_done("freerun");
    tick();
    check_eq("freerun_beats", beats, FRAME_BEATS);
    check_eq("freerun_sb", sb.size(), 0);

    // Sink backpressure.
    ready_mode = 1;
    beats = 0;
    push_frame();
    pulse_start();
    wait_done("backpressure");
    tick();
    check_eq("bp_beats", beats, FRAME_BEATS);
    check_eq("bp_sb", sb.size(), 0);
    ready_mode = 0;
    tick();

    // Framebuffer not ready for 5 cycles once address 5 has been issued.
    beats = 0;
    push_frame();
    pulse_start();
    begin
      int n;
      n = 0;
      while (addr_read != AW'(6) && n < 100) begin
        tick();
        n++;
      end
    end
    check_eq("stall_reach", addr_read, 6);
    buf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_addr", addr_read, 6);
    end
    buf_ready = 1'b1;
    wait_done("stall");
    tick();
    check_eq("stall_beats", beats, FRAME_BEATS);
    check_eq("stall_sb", sb.size(), 0);

    // Start while busy is ignored; start on the done cycle launches a new frame.
    beats = 0;
    push_frame();
    pulse_start();
    wait_beats(3);
    pulse_start();
    wait_done("busy_start");
    check_eq("busy_start_beats", beats, FRAME_BEATS);
    push_frame();
    beats = 0;
    pulse_start();
    check_eq("restart_busy", busy, 1);
    wait_done("restart");
    tick();
    check_eq("restart_beats", beats, FRAME_BEATS);
    check_eq("restart_sb", sb.size(), 0);

    // Reset mid-frame.
    beats = 0;
    push_frame();
    pulse_start();
    wait_beats(7);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", m_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_addr", addr_read, 0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    beats = 0;
    push_frame();
    pulse_start();
    wait_done("after_rst");
    repeat (3) tick();
    check_eq("after_rst_beats", beats, FRAME_BEATS);
    check_eq("after_rst_sb", sb.size(), 0);
    check_eq("done_total", done_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
